trim_sched: RTL and testbench

- Sequencer and arbiter that shares one frequency-trim engine among NCH oscillators.
- Latches per-channel calibration requests, grants the engine round-robin, and drives the engine's setb, select, target count, divider and start bit.
- Waits for trim completion, with a timeout, then stores each channel's final trim word in a result bank that feeds the oscillator cal inputs.
- Sits beside the trim engine in the always-on osc_clk domain.

---
 rtl/trim_sched.sv | 184 ++++++++++++++++++
 tb/tb_trim_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_sched.sv
// trim_sched: round-robin sequencer sharing one trim engine among NCH oscillators; TRIM_SCHED_PERIODIC_EN adds periodic recalibration.
// Latency: req edge to setb high 2+SETUP_CYC cycles, raw done to ack 3 cycles; no backpressure, requests wait as pending bits.
module trim_sched #(
  parameter int NCH       = 3,
  parameter int TW        = 16,
  parameter int TOW       = 20,
  parameter int SETUP_CYC = 4
) (
  input  logic                     osc_clk,
  input  logic                     rstb,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*16-1:0]        ref_cnt_tab,
  input  logic [7:0]               ref_div,
  input  logic [3:0]               from_msb,
  input  logic [TOW-1:0]           timeout,
`ifdef TRIM_SCHED_PERIODIC_EN
  input  logic [23:0]              period,
`endif
  output logic                     eng_setb,
  output logic [$clog2(NCH)-1:0]   eng_sel,
  output logic [15:0]              eng_ref_cnt,
  output logic [7:0]               eng_ref_div,
  output logic [3:0]               eng_from_msb,
  input  logic                     eng_trim_done,
  input  logic [TW-1:0]            eng_trim,
  output logic [NCH*TW-1:0]        cal,
  output logic [NCH-1:0]           ack,
  output logic [NCH-1:0]           err,
  output logic                     busy
);

  localparam int CW = $clog2(NCH);
  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [TW-1:0] CAL_RST = {1'b1, {(TW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_CAPTURE, S_RELEASE} state_t;

  state_t          state, state_nxt;
  logic [NCH-1:0]  req_d, pending, pend_set, gnt_mask;
  logic            done_m, done_s;
  logic [CW-1:0]   rr, gnt_ch, cand;
  logic            gnt_vld, grant;
  logic [SW-1:0]   cyc_cnt;
  logic            cyc_last;
  logic [TOW-1:0]  to_cnt;
  logic            to_hit, to_path;
  logic [TW-1:0]   cal_q [NCH];
  int              idx;

`ifdef TRIM_SCHED_PERIODIC_EN
  logic [23:0] per_cnt;
  logic        per_hit;

  assign per_hit = (period != '0) && (per_cnt == period - 24'd1);

  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb)                        per_cnt <= '0;
    else if (period == '0 || per_hit) per_cnt <= '0;
    else                              per_cnt <= per_cnt + 24'd1;
  end

  assign pend_set = (req & ~req_d) | {NCH{per_hit}};
`else
  assign pend_set = req & ~req_d;
`endif

  // An edge landing in the grant cycle survives the clear, so the channel runs again.
  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb) begin
      req_d   <= '0;
      pending <= '0;
    end else begin
      req_d   <= req;
      pending <= (pending & ~gnt_mask) | pend_set;
    end
  end

  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= eng_trim_done;
      done_s <= done_m;
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx  = (int'(rr) + k) % NCH;
      cand = CW'(idx);
      if (!gnt_vld && pending[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  assign grant    = (state == S_IDLE) && gnt_vld && !done_s;
  assign gnt_mask = grant ? (NCH'(1) << gnt_ch) : '0;
  assign cyc_last = (cyc_cnt == SW'(SETUP_CYC - 1));
  assign to_hit   = (timeout != '0) && (to_cnt == timeout - TOW'(1));

  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (grant)    state_nxt = S_SETUP;
      S_SETUP:   if (cyc_last) state_nxt = S_RUN;
      S_RUN: begin
        if (done_s)      state_nxt = S_CAPTURE;
        else if (to_hit) state_nxt = S_RELEASE;
      end
      S_CAPTURE:           state_nxt = S_RELEASE;
      S_RELEASE: if (cyc_last) state_nxt = S_IDLE;
      default:             state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    eng_setb = 1'b0;
    busy     = 1'b1;
    ack      = '0;
    case (state)
      S_IDLE:           busy     = 1'b0;
      S_RUN, S_CAPTURE: eng_setb = 1'b1;
      default: ;
    endcase
    if (state == S_CAPTURE || (state == S_RELEASE && to_path && cyc_cnt == '0))
      ack = NCH'(1) << eng_sel;
  end

  // Engine configuration is only ever loaded at grant, so it stays frozen for the whole run.
  always_ff @(posedge osc_clk or negedge rstb) begin
    if (!rstb) begin
      cyc_cnt      <= '0;
      to_cnt       <= '0;
      to_path      <= 1'b0;
      rr           <= CW'(NCH - 1);
      eng_sel      <= '0;
      eng_ref_cnt  <= '0;
      eng_ref_div  <= '0;
      eng_from_msb <= '0;
      err          <= '0;
      for (int i = 0; i < NCH; i++) cal_q[i] <= CAL_RST;
    end else begin
      cyc_cnt <= (state_nxt != state) ? '0 : cyc_cnt + 1'b1;
      if (state == S_SETUP)
        to_cnt <= '0;
      else if (state == S_RUN && to_cnt != '1)
        to_cnt <= to_cnt + 1'b1;
      if (grant) begin
        rr           <= gnt_ch;
        eng_sel      <= gnt_ch;
        eng_ref_cnt  <= ref_cnt_tab[16*gnt_ch +: 16];
        eng_ref_div  <= ref_div;
        eng_from_msb <= from_msb;
        to_path      <= 1'b0;
      end
      if (state == S_RUN) begin
        if (done_s) begin
          cal_q[eng_sel] <= eng_trim;
          err[eng_sel]   <= 1'b0;
        end else if (to_hit) begin
          err[eng_sel]   <= 1'b1;
          to_path        <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cal
    assign cal[g*TW +: TW] = cal_q[g];
  end

endmodule

// File: tb/tb_trim_sched.sv
// Bench for trim_sched: behavioural trim engine, ack scoreboard, vector table and timing sequences.
module tb_trim_sched;
  localparam int NCH = 3;
  localparam int TW  = 16;
  localparam int TOW = 20;
  localparam int SETUP_CYC = 4;

  logic              osc_clk, rstb;
  logic [NCH-1:0]    req;
  logic [NCH*16-1:0] ref_cnt_tab;
  logic [7:0]        ref_div;
  logic [3:0]        from_msb;
  logic [TOW-1:0]    timeout;
  logic              eng_setb;
  logic [1:0]        eng_sel;
  logic [15:0]       eng_ref_cnt;
  logic [7:0]        eng_ref_div;
  logic [3:0]        eng_from_msb;
  logic              eng_trim_done;
  logic [TW-1:0]     eng_trim;
  logic [NCH*TW-1:0] cal;
  logic [NCH-1:0]    ack, err;
  logic              busy;

  trim_sched #(.NCH(NCH), .TW(TW), .TOW(TOW), .SETUP_CYC(SETUP_CYC)) dut (
    .osc_clk(osc_clk), .rstb(rstb), .req(req), .ref_cnt_tab(ref_cnt_tab),
    .ref_div(ref_div), .from_msb(from_msb), .timeout(timeout),
    .eng_setb(eng_setb), .eng_sel(eng_sel), .eng_ref_cnt(eng_ref_cnt),
    .eng_ref_div(eng_ref_div), .eng_from_msb(eng_from_msb),
    .eng_trim_done(eng_trim_done), .eng_trim(eng_trim),
    .cal(cal), .ack(ack), .err(err), .busy(busy)
  );

  typedef struct {int ch; logic [15:0] cal; logic err;} exp_t;
  typedef struct {int ch; int to; int dly; logic [15:0] trim; logic [15:0] exp_cal; logic exp_err;} vec_t;

  exp_t        sb[$];
  vec_t        tbl[8];
  int          n_vec = 0;
  int          n_err = 0;
  int          eng_dly[NCH];
  logic [15:0] eng_val[NCH];
  int          rc;
  logic [1:0]  last_sel;
  logic        last_setb;

  initial begin
    osc_clk = 1'b0;
    forever #5 osc_clk = ~osc_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Engine: raises done dly cycles after setb rises, drops it as soon as setb falls.
  initial begin
    eng_trim_done = 1'b0;
    eng_trim      = '0;
    rc            = 0;
    forever begin
      @(negedge osc_clk);
      if (!eng_setb) begin
        eng_trim_done = 1'b0;
        rc = 0;
      end else begin
        rc++;
        if (eng_dly[eng_sel] != 0 && rc >= eng_dly[eng_sel] && !eng_trim_done) begin
          eng_trim_done = 1'b1;
          eng_trim      = eng_val[eng_sel];
        end
      end
    end
  end

  initial begin
    exp_t e;
    last_sel  = '0;
    last_setb = 1'b0;
    forever begin
      @(negedge osc_clk);
      if (rstb && ack != '0) begin
        if (sb.size() == 0) check("ack_unexpected", ack, 0);
        else begin
          e = sb.pop_front();
          check("ack_chan", ack, 64'(1) << e.ch);
          check("cal_at_ack", cal[e.ch*16 +: 16], e.cal);
          check("err_at_ack", err[e.ch], e.err);
        end
      end
      if (rstb && eng_sel != last_sel) check("setb_across_grant", {last_setb, eng_setb}, 0);
      last_sel  = eng_sel;
      last_setb = eng_setb;
    end
  end

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic pulse_req(input logic [NCH-1:0] m);
    req = m;
    tick();
    req = '0;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({"drain_", nm}, {sb.size() == 0, busy}, 2'b10);
  endtask

  task automatic wait_setb(input int budget, output int n);
    n = 0;
    while (!eng_setb && n < budget) begin
      tick();
      n++;
    end
    check("setb_rise", eng_setb, 1);
  endtask

  initial begin
    int n, lo, k;
    logic [NCH-1:0] m;
    rstb = 1'b0; req = '0; timeout = '0;
    ref_cnt_tab = {16'h0333, 16'h0222, 16'h0111};
    ref_div = 8'h12; from_msb = 4'h9;
    eng_dly = '{0, 0, 0};
    eng_val = '{16'h0, 16'h0, 16'h0};

    tbl[0] = '{0,   0, 15, 16'h1234, 16'h1234, 1'b0};
    tbl[1] = '{2,   0,  3, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[2] = '{1,  30,  0, 16'h0000, 16'h005A, 1'b1};
    tbl[3] = '{1,  30, 10, 16'h0001, 16'h0001, 1'b0};
    tbl[4] = '{0,   8,  0, 16'h0000, 16'h1234, 1'b1};
    tbl[5] = '{2, 100,  1, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{0,   0,  1, 16'h8001, 16'h8001, 1'b0};
    tbl[7] = '{2,   1,  0, 16'h0000, 16'h0000, 1'b1};

    repeat (3) tick();
    check("rst_cal", cal, 48'h8000_8000_8000);
    check("rst_setb", eng_setb, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_sel", eng_sel, 0);
    check("rst_refcnt", eng_ref_cnt, 0);
    check("rst_refdiv", {eng_ref_div, eng_from_msb}, 0);
    rstb = 1'b1;
    tick();

    // Simultaneous requests from reset: rr starts at NCH-1, so order is 0,1,2.
    eng_dly = '{20, 30, 25};
    eng_val = '{16'h0A01, 16'h0B02, 16'h0C03};
    sb.push_back('{0, 16'h0A01, 1'b0});
    sb.push_back('{1, 16'h0B02, 1'b0});
    sb.push_back('{2, 16'h0C03, 1'b0});
    pulse_req(3'b111);
    wait_drain(2000, "simul");

    // Single request on ch1: latency, setup width, frozen config, done-to-ack timing.
    eng_dly[1] = 200; eng_val[1] = 16'h005A;
    sb.push_back('{1, 16'h005A, 1'b0});
    req = 3'b010; n = 0; lo = 0;
    while (!eng_setb && n < 50) begin
      tick();
      n++;
      if (n == 1) req = '0;
      if (busy && !eng_setb) lo++;
    end
    check("req_to_setb", n, 2 + SETUP_CYC);
    check("setup_low_cycles", lo, SETUP_CYC);
    check("sel_ch1", eng_sel, 1);
    check("refcnt_ch1", eng_ref_cnt, 16'h0222);
    ref_div = 8'hEE; from_msb = 4'h3; ref_cnt_tab = 48'hAAAA_BBBB_CCCC;
    k = 0;
    while (!eng_trim_done && k < 400) begin tick(); k++; end
    check("done_seen", eng_trim_done, 1);
    check("ack_done_plus1", ack, 0);
    tick();
    check("ack_done_plus2", ack, 0);
    check("refdiv_frozen", eng_ref_div, 8'h12);
    tick();
    check("ack_done_plus3", ack, 3'b010);
    check("frommsb_frozen", eng_from_msb, 4'h9);
    check("refcnt_frozen", eng_ref_cnt, 16'h0222);
    wait_drain(1000, "ch1");

    // Timeout on ch2 with ch0 queued behind it.
    timeout = 20'd50; eng_dly[2] = 0; eng_dly[0] = 10; eng_val[0] = 16'h0D0D;
    sb.push_back('{2, 16'h0C03, 1'b1});
    sb.push_back('{0, 16'h0D0D, 1'b0});
    req = 3'b100; tick(); req = 3'b001; tick(); req = '0;
    wait_setb(50, n);
    check("sel_ch2", eng_sel, 2);
    k = 0;
    while (!err[2] && k < 200) begin tick(); k++; end
    check("timeout_cycles", k, 50);
    check("ack_on_timeout", ack, 3'b100);
    check("cal2_kept", cal[47:32], 16'h0C03);
    wait_drain(1000, "timeout");
    timeout = '0;

    // Re-edge on ch0 during its own run gives a second back-to-back run.
    eng_dly[0] = 40; eng_val[0] = 16'h4444;
    sb.push_back('{0, 16'h4444, 1'b0});
    sb.push_back('{0, 16'h5555, 1'b0});
    pulse_req(3'b001);
    wait_setb(50, n);
    pulse_req(3'b001);
    k = 0;
    while (!ack[0] && k < 300) begin tick(); k++; end
    check("first_ack0", ack, 3'b001);
    eng_val[0] = 16'h5555;
    wait_drain(1000, "rerun");

    for (int i = 0; i < 8; i++) begin
      timeout = TOW'(tbl[i].to);
      eng_dly[tbl[i].ch] = tbl[i].dly;
      eng_val[tbl[i].ch] = tbl[i].trim;
      sb.push_back('{tbl[i].ch, tbl[i].exp_cal, tbl[i].exp_err});
      m = '0;
      m[tbl[i].ch] = 1'b1;
      pulse_req(m);
      wait_drain(1000, "vec");
    end
    check("err_vec_final", err, 3'b100);
    timeout = '0;

    // Reset in the middle of a run.
    eng_dly[2] = 0;
    pulse_req(3'b100);
    wait_setb(50, n);
    repeat (5) tick();
    check("midrun_busy", busy, 1);
    rstb = 1'b0;
    #1;
    check("arst_setb", eng_setb, 0);
    check("arst_busy", busy, 0);
    check("arst_cal", cal, 48'h8000_8000_8000);
    check("arst_err", err, 0);
    check("arst_ack", ack, 0);
    check("arst_sel", eng_sel, 0);
    check("arst_refcnt", eng_ref_cnt, 0);
    tick();
    rstb = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
